// File: rtl/down_counter_timer.sv
// Loadable down-counter/timer: counts a loaded value down to zero on enabled edges,
// pulses terminal at the end and then either stops in DONE or reloads and keeps running.
module down_counter_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] counter_out,
  output logic             busy,
  output logic             terminal,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             terminal_q, terminal_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Next-state: load wins over everything; only RUN reacts to enable.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    reload_d   = reload_q;
    terminal_d = 1'b0;
    if (load) begin
      count_d  = load_value;
      reload_d = load_value;
      if (load_value != ZERO) begin
        state_d = RUN;
      end else begin
        state_d = DONE;
      end
    end else begin
      case (state_q)
        RUN: begin
          if (enable) begin
            // A count of 1 (or a defensive 0) is the terminal edge, so we never wrap.
            if (count_q > ONE) begin
              count_d = count_q - ONE;
            end else begin
              terminal_d = 1'b1;
              if (auto_reload) begin
                count_d = reload_q;
              end else begin
                count_d = ZERO;
                state_d = DONE;
              end
            end
          end else begin
            count_d = count_q;
          end
        end
        IDLE:    state_d = IDLE;
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  // State and registered status outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      count_q    <= ZERO;
      reload_q   <= ZERO;
      terminal_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      reload_q   <= reload_d;
      terminal_q <= terminal_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign counter_out = count_q;
  assign busy        = busy_q;
  assign terminal    = terminal_q;
  assign done        = done_q;

endmodule

// File: tb/tb_down_counter_timer.sv
// Directed plus randomized bench for down_counter_timer against a behavioural model.
module tb_down_counter_timer;
  localparam int W = 4;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_value = '0;
  logic         enable = 1'b0;
  logic         auto_reload = 1'b0;
  logic [W-1:0] counter_out;
  logic         busy;
  logic         terminal;
  logic         done;

  int checks = 0;
  int failures = 0;

  // Behavioural model: mode 0 = idle, 1 = running, 2 = finished.
  int m_cnt = 0;
  int m_rel = 0;
  int m_mode = 0;
  int m_term = 0;

  down_counter_timer #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset), .load(load), .load_value(load_value),
    .enable(enable), .auto_reload(auto_reload), .counter_out(counter_out),
    .busy(busy), .terminal(terminal), .done(done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_rel = 0; m_mode = 0; m_term = 0;
  endtask

  task automatic model_edge(input bit ld, input int lv, input bit en, input bit ar);
    m_term = 0;
    if (ld) begin
      m_cnt  = lv;
      m_rel  = lv;
      m_mode = (lv == 0) ? 2 : 1;
    end else if (m_mode == 1 && en) begin
      if (m_cnt == 1) begin
        m_term = 1;
        if (ar) m_cnt = m_rel;
        else begin
          m_cnt  = 0;
          m_mode = 2;
        end
      end else begin
        m_cnt = m_cnt - 1;
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".count"}, {28'd0, counter_out}, m_cnt);
    chk({tag, ".busy"}, {31'd0, busy}, (m_mode == 1) ? 32'd1 : 32'd0);
    chk({tag, ".terminal"}, {31'd0, terminal}, m_term);
    chk({tag, ".done"}, {31'd0, done}, (m_mode == 2) ? 32'd1 : 32'd0);
  endtask

  task automatic step(input string tag, input bit ld, input int lv, input bit en, input bit ar);
    load        = ld;
    load_value  = lv[W-1:0];
    enable      = en;
    auto_reload = ar;
    @(posedge clock);
    model_edge(ld, lv, en, ar);
    #1;
    check_all(tag);
  endtask

  initial begin
    int basic_exp[5];
    int gap_en[5];
    int gap_exp[5];
    int ar_exp[9];
    int edges;
    basic_exp = '{4, 3, 2, 1, 0};
    gap_en    = '{1, 0, 0, 1, 1};
    gap_exp   = '{2, 2, 2, 1, 0};
    ar_exp    = '{2, 1, 3, 2, 1, 3, 2, 1, 3};

    // Reset state while held in reset.
    #1;
    check_all("por");
    #2 reset = 1'b1;

    // 1. Reset mid-run.
    step("rst_load", 1'b1, 9, 1'b0, 1'b0);
    step("rst_run0", 1'b0, 0, 1'b1, 1'b0);
    step("rst_run1", 1'b0, 0, 1'b1, 1'b0);
    #2 reset = 1'b0;
    #1;
    model_reset();
    chk("rst_async.count", {28'd0, counter_out}, 32'd0);
    chk("rst_async.busy", {31'd0, busy}, 32'd0);
    chk("rst_async.done", {31'd0, done}, 32'd0);
    chk("rst_async.terminal", {31'd0, terminal}, 32'd0);
    #2 reset = 1'b1;
    step("rst_idle0", 1'b0, 0, 1'b1, 1'b0);
    step("rst_idle1", 1'b0, 0, 1'b1, 1'b1);

    // 2. Basic count to zero, then stop.
    step("basic_load", 1'b1, 5, 1'b1, 1'b0);
    chk("basic_load.lit", {28'd0, counter_out}, 32'd5);
    for (int i = 0; i < 5; i++) begin
      step("basic_cnt", 1'b0, 0, 1'b1, 1'b0);
      chk("basic_cnt.lit", {28'd0, counter_out}, basic_exp[i]);
      chk("basic_term.lit", {31'd0, terminal}, (i == 4) ? 32'd1 : 32'd0);
    end
    chk("basic_done.lit", {31'd0, done}, 32'd1);
    for (int i = 0; i < 4; i++) step("basic_hold", 1'b0, 0, 1'b1, 1'b0);

    // 3. Enable gaps.
    step("gap_load", 1'b1, 3, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step("gap_cnt", 1'b0, 0, gap_en[i][0], 1'b0);
      chk("gap_cnt.lit", {28'd0, counter_out}, gap_exp[i]);
    end

    // 4. Auto-reload.
    step("ar_load", 1'b1, 3, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) begin
      step("ar_cnt", 1'b0, 0, 1'b1, 1'b1);
      chk("ar_cnt.lit", {28'd0, counter_out}, ar_exp[i]);
      chk("ar_term.lit", {31'd0, terminal}, (ar_exp[i] == 3) ? 32'd1 : 32'd0);
    end

    // 5. Load colliding with the terminal edge.
    step("col_load", 1'b1, 2, 1'b0, 1'b0);
    step("col_dec", 1'b0, 0, 1'b1, 1'b0);
    step("col_hit", 1'b1, 7, 1'b1, 1'b0);
    chk("col_hit.lit", {28'd0, counter_out}, 32'd7);
    chk("col_term.lit", {31'd0, terminal}, 32'd0);
    chk("col_busy.lit", {31'd0, busy}, 32'd1);

    // 6. Boundaries: load 0, then full-scale load.
    step("zero_load", 1'b1, 0, 1'b1, 1'b0);
    chk("zero_done.lit", {31'd0, done}, 32'd1);
    chk("zero_term.lit", {31'd0, terminal}, 32'd0);
    step("max_load", 1'b1, 15, 1'b1, 1'b0);
    edges = 0;
    while (terminal !== 1'b1 && edges < 20) begin
      step("max_cnt", 1'b0, 0, 1'b1, 1'b0);
      edges++;
    end
    chk("max_edges", edges, 32'd15);
    step("max_hold", 1'b0, 0, 1'b1, 1'b0);
    chk("max_hold.lit", {28'd0, counter_out}, 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      step("rand", ($urandom % 8) == 0, int'($urandom % 16), ($urandom % 4) != 0, ($urandom % 2) == 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
